// File: rtl/noc_packet_sink.sv
// noc_packet_sink: NoC endpoint receiver that checks framing, payload and sequence tags and counts packets
module noc_packet_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int X_ID = 0,
  parameter int Y_ID = 0,
  parameter logic [7:0] BP_PATTERN = 8'hFF
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic                  receive_valid,
  output logic                  receive_ready,
  input  logic [DATA_WIDTH-1:0] receive_flit,
  input  logic                  receive_is_header,
  input  logic                  receive_is_tail,
  output logic [7:0]            receive_num,
  output logic [7:0]            error_num,
  output logic [2:0]            err_code,
  output logic                  err_pulse,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, BODY, DRAIN} state_t;
  localparam logic [7:0] NODE = {4'(X_ID), 4'(Y_ID)};
  state_t state, nxt;
  logic [2:0] phase, code, idle_code, body_code;
  logic [7:0] len, k, cur_tag, last_tag, f_len, f_tag;
  logic [15:0] f_k;
  logic first_pkt, tag_bad, acc, new_err, tag_err, good, close_bad, report, count_err;
  assign acc = receive_valid & receive_ready;
  assign f_len = receive_flit[23:16];
  assign f_tag = receive_flit[31:24];
  assign f_k = receive_flit[15:0];
  assign busy = state != IDLE;
  assign idle_code = !receive_is_header ? 3'd1 :
                     receive_flit[7:0] != NODE ? 3'd2 :
                     (f_len < 8'd2 || receive_is_tail) ? 3'd5 :
                     (!first_pkt && f_tag != last_tag + 8'd1) ? 3'd6 : 3'd0;
  assign body_code = receive_is_header ? 3'd4 :
                     (f_k != {8'd0, k} || f_tag != cur_tag) ? 3'd3 :
                     (receive_is_tail != (k == len - 8'd1)) ? 3'd5 : 3'd0;
  assign code = state == IDLE ? idle_code : state == BODY ? body_code : 3'd0;
  // a bad sequence tag still lets the packet run; it is only counted once its tail arrives
  assign tag_err = acc && state == IDLE && idle_code == 3'd6;
  assign new_err = acc && code != 3'd0 && !tag_err;
  assign good = acc && state == BODY && receive_is_tail && body_code == 3'd0 && !tag_bad;
  assign close_bad = acc && state != IDLE && receive_is_tail && tag_bad;
  assign report = (new_err && !tag_bad) || tag_err;
  assign count_err = (new_err && !tag_bad) || close_bad;
  assign nxt = !acc ? state : receive_is_tail ? IDLE : (new_err || state == DRAIN) ? DRAIN : BODY;
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state <= IDLE;
      phase <= 3'd0;
      receive_ready <= 1'b0;
      receive_num <= 8'd0;
      error_num <= 8'd0;
      err_code <= 3'd0;
      err_pulse <= 1'b0;
      len <= 8'd0;
      k <= 8'd0;
      cur_tag <= 8'd0;
      last_tag <= 8'd0;
      first_pkt <= 1'b1;
      tag_bad <= 1'b0;
    end else begin
      state <= nxt;
      phase <= phase + 3'd1;
      receive_ready <= BP_PATTERN[phase];
      err_pulse <= report;
      if (report) err_code <= code;
      if (good && receive_num != 8'hFF) receive_num <= receive_num + 8'd1;
      if (count_err && error_num != 8'hFF) error_num <= error_num + 8'd1;
      if (acc && state == IDLE && receive_is_header) begin
        last_tag <= f_tag;
        cur_tag <= f_tag;
        len <= f_len;
        first_pkt <= 1'b0;
      end
      k <= (acc && state == IDLE) ? 8'd1 : (acc && state == BODY) ? k + 8'd1 : k;
      tag_bad <= tag_err || (tag_bad && !close_bad);
    end
  end
endmodule

// File: tb/tb_noc_packet_sink.sv
// tb_noc_packet_sink: packet-level scoreboard bench for noc_packet_sink with randomized faults
module tb_noc_packet_sink;
  localparam logic [7:0] BP = 8'b01010101;
  localparam int F_OK = 0, F_DEST = 1, F_PAY = 2, F_TAG = 3, F_EARLY = 4, F_LATE = 5, F_NOHDR = 6, F_HDRBODY = 7, F_LEN1 = 8;
  logic noc_clk = 1'b0, noc_rst_n = 1'b0;
  logic receive_valid = 1'b0, receive_is_header = 1'b0, receive_is_tail = 1'b0;
  logic [31:0] receive_flit = 32'd0;
  logic receive_ready, err_pulse, busy;
  logic [7:0] receive_num, error_num;
  logic [2:0] err_code;
  int tests = 0, fails = 0, cyc = 0, acc_cnt = 0, erx = 0, eerr = 0;
  int pulse_q[$];
  bit out_q[$];
  logic [7:0] mtag = 8'hFF;
  bit mseen = 1'b0;
  logic [7:0] bp_v = BP;

  noc_packet_sink #(.DATA_WIDTH(32), .X_ID(1), .Y_ID(1), .BP_PATTERN(BP)) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .receive_valid(receive_valid), .receive_ready(receive_ready),
    .receive_flit(receive_flit), .receive_is_header(receive_is_header), .receive_is_tail(receive_is_tail),
    .receive_num(receive_num), .error_num(error_num), .err_code(err_code),
    .err_pulse(err_pulse), .busy(busy)
  );

  always #5 noc_clk = ~noc_clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // monitor: pops expected pulses and packet outcomes as the DUT shows them
  always @(posedge noc_clk) begin
    bit acc_s, tail_s, bad;
    int c;
    acc_s = noc_rst_n && receive_valid && receive_ready;
    tail_s = acc_s && receive_is_tail;
    #1;
    if (!noc_rst_n) begin
      cyc = 0;
      erx = 0;
      eerr = 0;
    end else begin
      cyc++;
      if (acc_s) acc_cnt++;
      chk("ready_phase", int'(receive_ready), int'(bp_v[(cyc - 1) % 8]));
      if (err_pulse) begin
        if (pulse_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL err_pulse: got 1 with code %0d, expected 0", err_code);
        end else begin
          c = pulse_q.pop_front();
          chk("err_code", int'(err_code), c);
        end
      end
      if (tail_s) begin
        if (out_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tail_outcome: got tail, expected no packet pending");
        end else begin
          bad = out_q.pop_front();
          if (bad) eerr = eerr < 255 ? eerr + 1 : 255;
          else erx = erx < 255 ? erx + 1 : 255;
          chk("receive_num", int'(receive_num), erx);
          chk("error_num", int'(error_num), eerr);
          chk("busy_after_tail", int'(busy), 0);
        end
      end
    end
  end

  task automatic send(input logic [31:0] f, input logic h, input logic t);
    int w = 0;
    receive_valid = 1'b1;
    receive_flit = f;
    receive_is_header = h;
    receive_is_tail = t;
    while (!receive_ready && w < 64) begin
      @(negedge noc_clk);
      w++;
    end
    if (w == 64) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got ready=0 for %0d cycles, expected ready", w);
    end
    @(negedge noc_clk);
  endtask

  task automatic idle(input int n);
    receive_valid = 1'b0;
    receive_is_header = 1'b0;
    receive_is_tail = 1'b0;
    repeat (n) @(negedge noc_clk);
  endtask

  function automatic logic [31:0] pay(input logic [7:0] t, input int k);
    return {t, 8'($urandom), 16'(k)};
  endfunction

  // packet-level reference: the first fault in a packet decides its code; each packet closes once
  task automatic packet(input int fault, input int len, input int j);
    logic [7:0] tag, dest, hl;
    logic [31:0] f;
    int code, last;
    tag = (fault == F_DEST || fault == F_LEN1) ? mtag : fault == F_TAG ? mtag + 8'(2 + j) : mtag + 8'd1;
    code = fault == F_DEST ? 2 : fault == F_NOHDR ? 1 : fault == F_TAG ? 6 : fault == F_PAY ? 3 :
           fault == F_HDRBODY ? 4 : (fault == F_LEN1 || fault == F_EARLY || fault == F_LATE) ? 5 : 0;
    if (fault == F_TAG && !mseen) code = 0;
    if (fault != F_NOHDR) mtag = tag;
    if (fault != F_NOHDR && fault != F_DEST && fault != F_LEN1) mseen = 1'b1;
    if (code != 0) pulse_q.push_back(code);
    out_q.push_back(code != 0);
    dest = fault == F_DEST ? 8'h01 : 8'h11;
    hl = fault == F_LEN1 ? 8'($urandom_range(0, 1)) : 8'(len);
    if (fault == F_NOHDR) begin
      for (int k = 0; k < len; k++) send(pay(tag, k), 1'b0, k == len - 1);
    end else if (fault == F_LEN1) begin
      send({tag, hl, 8'h23, dest}, 1'b1, 1'b0);
      send(pay(tag, 1), 1'b0, 1'b1);
    end else begin
      send({tag, hl, 8'h23, dest}, 1'b1, 1'b0);
      last = fault == F_EARLY ? j : len - 1;
      for (int k = 1; k <= last; k++) begin
        f = pay(tag, k);
        if (fault == F_PAY && k == j) f = (j % 2 == 0) ? {f[31:16], 16'(k + 5)} : f ^ 32'h8000_0000;
        send(f, fault == F_HDRBODY && k == j, k == last && fault != F_LATE);
      end
      if (fault == F_LATE) send(pay(tag, len), 1'b0, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int a0, fault, len, j;
    repeat (3) @(negedge noc_clk);
    chk("rst_ready", int'(receive_ready), 0);
    chk("rst_receive_num", int'(receive_num), 0);
    chk("rst_error_num", int'(error_num), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_err_pulse", int'(err_pulse), 0);
    chk("rst_busy", int'(busy), 0);
    noc_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) packet(F_OK, 4, 0);
    a0 = acc_cnt;
    packet(F_OK, 6, 0);
    chk("accepts_len6", acc_cnt - a0, 6);
    packet(F_DEST, 3, 0);
    chk("dest_code", int'(err_code), 2);
    packet(F_OK, 3, 0);
    packet(F_PAY, 5, 2);
    chk("pay_code", int'(err_code), 3);
    packet(F_OK, 4, 0);
    packet(F_TAG, 4, 0);
    chk("tag_code", int'(err_code), 6);
    packet(F_OK, 4, 0);
    for (int i = 0; i < 150; i++) begin
      fault = $urandom_range(0, 8);
      if (fault == F_TAG && !mseen) fault = F_OK;
      len = $urandom_range(2, 10);
      if ((fault == F_PAY || fault == F_EARLY || fault == F_HDRBODY) && len < 3) len = 3;
      j = fault == F_TAG ? $urandom_range(0, 200) : len >= 3 ? $urandom_range(1, len - 2) : 0;
      packet(fault, len, j);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    idle(1);
    send({mtag + 8'd1, 8'd4, 8'h23, 8'h11}, 1'b1, 1'b0);
    send(pay(mtag + 8'd1, 1), 1'b0, 1'b0);
    chk("busy_mid_packet", int'(busy), 1);
    receive_valid = 1'b0;
    noc_rst_n = 1'b0;
    #1;
    chk("midrst_ready", int'(receive_ready), 0);
    chk("midrst_receive_num", int'(receive_num), 0);
    chk("midrst_error_num", int'(error_num), 0);
    chk("midrst_busy", int'(busy), 0);
    repeat (2) @(negedge noc_clk);
    noc_rst_n = 1'b1;
    mtag = 8'($urandom);
    mseen = 1'b0;
    packet(F_OK, 3, 0);
    chk("post_reset_count", int'(receive_num), 1);
    for (int i = 0; i < 300; i++) packet(F_OK, 2, 0);
    idle(2);
    chk("receive_num_saturated", int'(receive_num), 255);
    chk("pulse_q_left", pulse_q.size(), 0);
    chk("out_q_left", out_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
